// File: rtl/ex_result_skid_reg.sv
// ============================================================================
// Module      : ex_result_skid_reg
// Description : EX->MEM result register with a two-entry skid buffer. The
//               ready output is driven only from registers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ex_result_skid_reg #(
    parameter int XLEN  = 32,
    parameter int SEL_W = 2
) (
    input  logic             CLK,
    input  logic             rst_n,
    input  logic [XLEN-1:0]  Arith_Result,
    input  logic [XLEN-1:0]  Logic_Result,
    input  logic [XLEN-1:0]  Shift_Result,
    input  logic [SEL_W-1:0] Unit_Sel,
    input  logic [4:0]       Rd_Addr,
    input  logic             Reg_Wr,
    input  logic             In_Valid,
    output logic             In_Ready,
    input  logic             Flush,
    output logic             Out_Valid,
    input  logic             Out_Ready,
    output logic [XLEN-1:0]  EX_Result,
    output logic [4:0]       Rd_Addr_Out,
    output logic             Reg_Wr_Out
);

    localparam logic [SEL_W-1:0] c_sel_arith = SEL_W'(0);
    localparam logic [SEL_W-1:0] c_sel_logic = SEL_W'(1);
    localparam logic [SEL_W-1:0] c_sel_shift = SEL_W'(2);

    logic [XLEN-1:0] r_main_res;
    logic [4:0]      r_main_rd;
    logic            r_main_wr;
    logic            r_main_vld;
    logic [XLEN-1:0] r_skid_res;
    logic [4:0]      r_skid_rd;
    logic            r_skid_wr;
    logic            r_skid_vld;

    logic [XLEN-1:0] w_in_res;
    logic            w_in_wr;
    logic            w_accept;
    logic            w_release;

    // Any unlisted select code (including 11) yields a zero result.
    always_comb begin
        w_in_res = '0;
        if (Unit_Sel == c_sel_arith) begin
            w_in_res = Arith_Result;
        end else if (Unit_Sel == c_sel_logic) begin
            w_in_res = Logic_Result;
        end else if (Unit_Sel == c_sel_shift) begin
            w_in_res = Shift_Result;
        end
    end

    assign w_in_wr   = Reg_Wr & (Rd_Addr != 5'd0);
    assign w_accept  = In_Valid & ~r_skid_vld;
    assign w_release = r_main_vld & Out_Ready;

    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            r_main_res <= '0;
            r_main_rd  <= '0;
            r_main_wr  <= 1'b0;
            r_main_vld <= 1'b0;
            r_skid_res <= '0;
            r_skid_rd  <= '0;
            r_skid_wr  <= 1'b0;
            r_skid_vld <= 1'b0;
        end else if (Flush) begin
            // Payloads are left as-is; only valids matter once flushed.
            r_main_vld <= 1'b0;
            r_skid_vld <= 1'b0;
        end else if (!r_main_vld) begin
            if (w_accept) begin
                r_main_res <= w_in_res;
                r_main_rd  <= Rd_Addr;
                r_main_wr  <= w_in_wr;
                r_main_vld <= 1'b1;
            end
        end else if (!r_skid_vld) begin
            if (w_accept && w_release) begin
                r_main_res <= w_in_res;
                r_main_rd  <= Rd_Addr;
                r_main_wr  <= w_in_wr;
            end else if (w_accept) begin
                r_skid_res <= w_in_res;
                r_skid_rd  <= Rd_Addr;
                r_skid_wr  <= w_in_wr;
                r_skid_vld <= 1'b1;
            end else if (w_release) begin
                r_main_vld <= 1'b0;
            end
        end else if (w_release) begin
            r_main_res <= r_skid_res;
            r_main_rd  <= r_skid_rd;
            r_main_wr  <= r_skid_wr;
            r_skid_res <= '0;
            r_skid_rd  <= '0;
            r_skid_wr  <= 1'b0;
            r_skid_vld <= 1'b0;
        end
    end

    assign In_Ready    = ~r_skid_vld;
    assign Out_Valid   = r_main_vld;
    assign EX_Result   = r_main_res;
    assign Rd_Addr_Out = r_main_rd;
    assign Reg_Wr_Out  = r_main_wr & r_main_vld;

endmodule

`default_nettype wire
